div_8by4: RTL and testbench

DIV_8BY4 -- requirements
Module: div_8by4

---
 rtl/div_8by4_pkg.sv | 20 ++
 rtl/div_8by4_if.sv | 29 ++
 rtl/div_8by4_controlador_div.sv | 71 +++++++
 rtl/registrador.sv | 29 ++
 rtl/div_8by4.sv | 110 +++++++++++
 tb/tb_div_8by4.sv | 172 +++++++++++++++++
 6 files changed

// File: rtl/div_8by4_pkg.sv
// div_8by4_pkg -- shared types and constants for the 8-by-4 restoring divider.
//   estado_t   : controller state encoding (ST_IDLE, ST_CALC, ST_END)
//   DIVIDEND_W : dividend / quotient width
//   DIVISOR_W  : divisor / remainder width
//   N_STEPS    : number of restoring steps per division
//   CNT_W      : width of the step counter
package div_8by4_pkg;

    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;
    localparam int N_STEPS    = 8;
    localparam int CNT_W      = $clog2(N_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_END  = 2'd2
    } estado_t;

endpackage

// File: rtl/div_8by4_if.sv
// div_8by4_if -- operand/result bundle of the divider.
//   en_i   : start request
//   A_i    : dividend
//   B_i    : divisor
//   Q_o    : quotient
//   R_o    : remainder
//   done_o : result valid
//   err_o  : divide-by-zero flag (only when DIV_ZERO_DETECT_EN is defined)
// Modports: master drives operands, slave (the divider) drives results.
interface div_8by4_if;
    import div_8by4_pkg::*;

    logic                  en_i;
    logic [DIVIDEND_W-1:0] A_i;
    logic [DIVISOR_W-1:0]  B_i;
    logic [DIVIDEND_W-1:0] Q_o;
    logic [DIVISOR_W-1:0]  R_o;
    logic                  done_o;
`ifdef DIV_ZERO_DETECT_EN
    logic                  err_o;

    modport master (output en_i, A_i, B_i, input  Q_o, R_o, done_o, err_o);
    modport slave  (input  en_i, A_i, B_i, output Q_o, R_o, done_o, err_o);
`else
    modport master (output en_i, A_i, B_i, input  Q_o, R_o, done_o);
    modport slave  (input  en_i, A_i, B_i, output Q_o, R_o, done_o);
`endif

endinterface

// File: rtl/div_8by4_controlador_div.sv
// controlador_div -- sequencing FSM and step counter of the divider.
//   clk_i    : clock
//   rst_i    : asynchronous active-low reset
//   en_i     : start request / hold request in ST_END
//   zero_i   : start with a zero divisor that skips the calculation
//   estado_o : current state
//   ultimo_o : high during the last restoring step
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_IDLE | waiting for en_i; results from the last run are held
//   ST_CALC | one restoring step per cycle, N_STEPS cycles
//   ST_END  | results valid, done_o high; held while en_i stays high
module controlador_div
    import div_8by4_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    en_i,
    input  logic    zero_i,
    output estado_t estado_o,
    output logic    ultimo_o
);

    estado_t          r_estado;
    estado_t          w_prox;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_prox;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_estado <= ST_IDLE;
            r_cnt    <= '0;
        end else begin
            r_estado <= w_prox;
            r_cnt    <= w_cnt_prox;
        end
    end

    assign ultimo_o = (r_estado == ST_CALC) && (r_cnt == CNT_W'(N_STEPS - 1));

    always_comb begin
        w_prox     = r_estado;
        w_cnt_prox = r_cnt;
        case (r_estado)
            ST_IDLE: begin
                if (en_i) begin
                    w_cnt_prox = '0;
                    w_prox     = zero_i ? ST_END : ST_CALC;
                end
            end
            ST_CALC: begin
                w_cnt_prox = r_cnt + 1'b1;
                if (ultimo_o) begin
                    w_prox = ST_END;
                end
            end
            ST_END: begin
                if (!en_i) begin
                    w_prox = ST_IDLE;
                end
            end
            default: begin
                w_prox = ST_IDLE;
            end
        endcase
    end

    assign estado_o = r_estado;

endmodule

// File: rtl/registrador.sv
// registrador -- generic W-bit register with load enable.
//   clk_i : clock
//   rst_i : asynchronous active-low reset, clears to zero
//   en_i  : load enable
//   d_i   : data in
//   q_o   : registered data out
module registrador #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= d_i;
        end
    end

    assign q_o = r_q;

endmodule

// File: rtl/div_8by4.sv
// div_8by4 -- 8-bit by 4-bit unsigned restoring divider, one step per cycle.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   bus   : div_8by4_if.slave (en_i, A_i, B_i in; Q_o, R_o, done_o[, err_o] out)
// Build option: DIV_ZERO_DETECT_EN -- a zero divisor jumps straight to ST_END
// with Q_o=0, R_o=0 and err_o=1. Without it a zero divisor runs the normal
// steps and yields Q_o=8'hFF, R_o=A[3:0].
module div_8by4
    import div_8by4_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    div_8by4_if.slave  bus
);

    estado_t               w_estado;
    logic                  w_ultimo;
    logic                  w_start;
    logic                  w_step;
    logic                  w_zero_start;
    logic                  w_ld_work;
    logic                  w_ld_res;
    logic                  w_ge;
    logic [DIVISOR_W:0]    w_rem_sh;
    logic [DIVISOR_W-1:0]  w_trial;
    logic [DIVIDEND_W-1:0] w_quot_d;
    logic [DIVISOR_W-1:0]  w_rem_d;
    logic [DIVIDEND_W-1:0] w_q_d;
    logic [DIVISOR_W-1:0]  w_r_d;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [DIVIDEND_W-1:0] r_q;
    logic [DIVISOR_W-1:0]  r_r;

    assign w_start = (w_estado == ST_IDLE) && bus.en_i;
    assign w_step  = (w_estado == ST_CALC);

`ifdef DIV_ZERO_DETECT_EN
    assign w_zero_start = w_start && (bus.B_i == '0);
`else
    assign w_zero_start = 1'b0;
`endif

    controlador_div u_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (bus.en_i),
        .zero_i   (w_zero_start),
        .estado_o (w_estado),
        .ultimo_o (w_ultimo)
    );

    // The partial remainder is always below the divisor after a step, so
    // 4 bits of storage suffice; the shifted value needs the 5th bit only
    // for the compare. When the compare passes the difference fits in
    // 4 bits, so the subtraction is done modulo 16.
    assign w_rem_sh = {r_rem, r_quot[DIVIDEND_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    assign w_trial  = w_rem_sh[DIVISOR_W-1:0] - r_div;

    assign w_ld_work = w_start || w_step;
    assign w_quot_d  = w_start ? bus.A_i : {r_quot[DIVIDEND_W-2:0], w_ge};
    assign w_rem_d   = w_start ? '0 : (w_ge ? w_trial : w_rem_sh[DIVISOR_W-1:0]);

    registrador #(.W(DIVIDEND_W)) u_reg_quot (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ld_work), .d_i (w_quot_d), .q_o (r_quot)
    );

    registrador #(.W(DIVISOR_W)) u_reg_rem (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ld_work), .d_i (w_rem_d), .q_o (r_rem)
    );

    registrador #(.W(DIVISOR_W)) u_reg_div (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (w_start), .d_i (bus.B_i), .q_o (r_div)
    );

    // Separate result registers keep Q_o/R_o stable through the next
    // calculation until its last step lands.
    assign w_ld_res = w_ultimo || w_zero_start;
    assign w_q_d    = w_zero_start ? '0 : w_quot_d;
    assign w_r_d    = w_zero_start ? '0 : w_rem_d;

    registrador #(.W(DIVIDEND_W)) u_reg_q (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ld_res), .d_i (w_q_d), .q_o (r_q)
    );

    registrador #(.W(DIVISOR_W)) u_reg_r (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (w_ld_res), .d_i (w_r_d), .q_o (r_r)
    );

`ifdef DIV_ZERO_DETECT_EN
    logic w_leave_end;
    logic r_err;

    assign w_leave_end = (w_estado == ST_END) && !bus.en_i;

    registrador #(.W(1)) u_reg_err (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (w_zero_start || w_leave_end),
        .d_i (w_zero_start), .q_o (r_err)
    );

    assign bus.err_o = r_err;
`endif

    assign bus.Q_o    = r_q;
    assign bus.R_o    = r_r;
    assign bus.done_o = (w_estado == ST_END);

endmodule

// File: tb/tb_div_8by4.sv
// tb_div_8by4 -- directed vectors plus an operand sweep for div_8by4.
// Follows DIV_ZERO_DETECT_EN the same way as the design.
module tb_div_8by4;
    import div_8by4_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] q_obs;
    logic [3:0] r_obs;
    int         lat_obs;
    logic       dn_after;
    logic       err_obs;

    div_8by4_if bus ();

    div_8by4 dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Start one division with en_i high for the start edge only, wait for
    // done_o (bounded), capture results, then confirm done_o drops.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r,
                           output int lat, output logic e, output logic dn2);
        @(negedge clk_i);
        bus.en_i = 1'b1;
        bus.A_i  = a;
        bus.B_i  = b;
        @(posedge clk_i);
        #1;
        bus.en_i = 1'b0;
        lat = 0;
        while (!bus.done_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        q = bus.Q_o;
        r = bus.R_o;
`ifdef DIV_ZERO_DETECT_EN
        e = bus.err_o;
`else
        e = 1'b0;
`endif
        @(posedge clk_i);
        #1;
        dn2 = bus.done_o;
    endtask

    task automatic check_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                             input logic [7:0] eq, input logic [3:0] er,
                             input int elat, input logic eerr);
        run_div(a, b, q_obs, r_obs, lat_obs, err_obs, dn_after);
        chk({tag, "_lat"}, lat_obs, elat);
        chk({tag, "_q"}, q_obs, eq);
        chk({tag, "_r"}, r_obs, er);
        chk({tag, "_done_drop"}, dn_after, 1'b0);
`ifdef DIV_ZERO_DETECT_EN
        chk({tag, "_err"}, err_obs, eerr);
        chk({tag, "_err_clr"}, bus.err_o, 1'b0);
`endif
    endtask

    initial begin
        rst_i    = 1'b1;
        bus.en_i = 1'b0;
        bus.A_i  = '0;
        bus.B_i  = '0;

        #3 rst_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_q", bus.Q_o, 0);
        chk("rst_r", bus.R_o, 0);
        chk("rst_done", bus.done_o, 0);
`ifdef DIV_ZERO_DETECT_EN
        chk("rst_err", bus.err_o, 0);
`endif
        @(negedge clk_i);
        rst_i = 1'b1;

        check_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 8, 1'b0);

        // Reset during the calculation: outputs (holding 28/4) clear at once.
        @(negedge clk_i);
        bus.en_i = 1'b1;
        bus.A_i  = 8'd150;
        bus.B_i  = 4'd9;
        @(posedge clk_i);
        #1;
        bus.en_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_q", bus.Q_o, 0);
        chk("mid_rst_r", bus.R_o, 0);
        chk("mid_rst_done", bus.done_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        check_div("d150_9", 8'd150, 4'd9, 8'd16, 4'd6, 8, 1'b0);

        check_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 8, 1'b0);
        check_div("d13_15", 8'd13, 4'd15, 8'd0, 4'd13, 8, 1'b0);
        check_div("d0_1", 8'd0, 4'd1, 8'd0, 4'd0, 8, 1'b0);

`ifdef DIV_ZERO_DETECT_EN
        check_div("d100_0", 8'd100, 4'd0, 8'd0, 4'd0, 0, 1'b1);
`else
        check_div("d100_0", 8'd100, 4'd0, 8'hFF, 4'd4, 8, 1'b0);
`endif

        // en_i held high, operands changed after the start edge.
        @(negedge clk_i);
        bus.en_i = 1'b1;
        bus.A_i  = 8'd77;
        bus.B_i  = 4'd5;
        @(posedge clk_i);
        #1;
        bus.A_i  = 8'd3;
        bus.B_i  = 4'd2;
        lat_obs  = 0;
        while (!bus.done_o && lat_obs < 20) begin
            @(posedge clk_i);
            #1;
            lat_obs++;
        end
        chk("hold_lat", lat_obs, 8);
        chk("hold_q", bus.Q_o, 15);
        chk("hold_r", bus.R_o, 2);
        repeat (3) begin
            @(posedge clk_i);
            #1;
        end
        chk("hold_done", bus.done_o, 1);
        chk("hold_q2", bus.Q_o, 15);
        @(negedge clk_i);
        bus.en_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("hold_drop", bus.done_o, 0);
        check_div("d9_4", 8'd9, 4'd4, 8'd2, 4'd1, 8, 1'b0);

        // Every nonzero-divisor pair against the division identity.
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_div(8'(a), 4'(b), q_obs, r_obs, lat_obs, err_obs, dn_after);
                chk("sweep_inv", 32'(q_obs) * 32'(b) + 32'(r_obs), 32'(a));
                chk("sweep_r_lt_b", {31'd0, (32'(r_obs) < 32'(b))}, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
